// File: rtl/mac_acc_ctrl.sv
// Saturating multiply-accumulate core with burst sequencer.
// Accepts N_TERMS operand pairs, then strobes ld_out with the result.
module mac_acc_ctrl #(
    parameter int DATA_W  = 4,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [ACC_W-1:0]  tout_acc,
    output logic              ld_out,
    output logic              busy,
    output logic              ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam int PRD_W = 2 * DATA_W;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [PRD_W-1:0]  prod;
    logic [SUM_W-1:0]  sum;
    logic              beat;

    assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    assign sum  = {1'b0, acc_q} + {{(SUM_W-PRD_W){1'b0}}, prod};
    assign beat = (state_q == ACCUM) && in_valid && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (beat) begin
                    // clamp at full scale and latch the sticky flag
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_TERMS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ACCUM);
    assign ld_out   = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign tout_acc = acc_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Bench for mac_acc_ctrl: two instances (4 and 20 terms) on shared
// stimulus, checked every cycle against a burst-level model.
module tb_mac_acc_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [3:0] a_in;
    logic [3:0] b_in;

    logic        rdy4, ld4, busy4, ovf4;
    logic [11:0] tout4;
    logic        rdy20, ld20, busy20, ovf20;
    logic [11:0] tout20;

    int tests;
    int fails;

    mac_acc_ctrl #(.DATA_W(4), .ACC_W(12), .N_TERMS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(rdy4),
        .a_in(a_in), .b_in(b_in),
        .tout_acc(tout4), .ld_out(ld4), .busy(busy4), .ovf(ovf4)
    );

    mac_acc_ctrl #(.DATA_W(4), .ACC_W(12), .N_TERMS(20)) u_dut20 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(rdy20),
        .a_in(a_in), .b_in(b_in),
        .tout_acc(tout20), .ld_out(ld20), .busy(busy20), .ovf(ovf20)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting, 1 = collecting, 2 = result cycle
    int nterm [2] = '{4, 20};
    int phase [2] = '{0, 0};
    int acc   [2] = '{0, 0};
    int cnt   [2] = '{0, 0};
    int movf  [2] = '{0, 0};

    always @(negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; acc[k] = 0; cnt[k] = 0; movf[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if (phase[k] == 0) begin
                    if (start && !abort) begin
                        phase[k] = 1; acc[k] = 0; cnt[k] = 0; movf[k] = 0;
                    end
                end else if (phase[k] == 2) begin
                    phase[k] = 0;
                end else if (abort) begin
                    phase[k] = 0; acc[k] = 0; cnt[k] = 0;
                end else if (in_valid) begin
                    acc[k] = acc[k] + int'(a_in) * int'(b_in);
                    if (acc[k] > 4095) begin
                        acc[k] = 4095; movf[k] = 1;
                    end
                    cnt[k]++;
                    if (cnt[k] == nterm[k]) phase[k] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("tout4", int'(tout4), acc[0]);
        chk("ld4", int'(ld4), int'(phase[0] == 2));
        chk("rdy4", int'(rdy4), int'(phase[0] == 1));
        chk("busy4", int'(busy4), int'(phase[0] != 0));
        chk("ovf4", int'(ovf4), movf[0]);
        chk("tout20", int'(tout20), acc[1]);
        chk("ld20", int'(ld20), int'(phase[1] == 2));
        chk("rdy20", int'(rdy20), int'(phase[1] == 1));
        chk("busy20", int'(busy20), int'(phase[1] != 0));
        chk("ovf20", int'(ovf20), movf[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b);
        in_valid = 1'b1;
        a_in = 4'(a);
        b_in = 4'(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Leaves the bench at the negedge where ld_out is high
    task automatic wait_ld(input int which, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? ld4 : ld20;
        end
        chk("ld_timeout", int'(seen), 1);
    endtask

    int pa [4] = '{3, 2, 15, 1};
    int pb [4] = '{5, 7, 15, 1};

    initial begin
        tests = 0; fails = 0;
        start = 0; abort = 0; in_valid = 0; a_in = 0; b_in = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_tout", int'(tout4), 0);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_ready", int'(rdy4), 0);
        tick();
        rst = 1'b1;

        // 1: back-to-back burst
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) beat(pa[i], pb[i]);
        @(negedge clk);
        chk("t1_ld", int'(ld4), 1);
        chk("t1_tout", int'(tout4), 255);
        chk("t1_ovf", int'(ovf4), 0);
        @(negedge clk);
        chk("t1_ld_once", int'(ld4), 0);
        chk("t1_idle", int'(busy4), 0);

        // 2: bubbles between beats
        tick();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            beat(pa[i], pb[i]);
            if (i < 3) begin
                tick(); tick();
            end
        end
        wait_ld(0, 3);
        chk("t2_tout", int'(tout4), 255);

        // 3: long saturating burst on the 20-term instance
        do_reset();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 20; i++) beat(15, 15);
        wait_ld(1, 3);
        chk("t3_tout", int'(tout20), 4095);
        chk("t3_ovf", int'(ovf20), 1);
        tick();
        start = 1; tick(); start = 0;
        @(negedge clk);
        chk("t3_ovf_clr", int'(ovf20), 0);
        chk("t3_tout_clr", int'(tout20), 0);
        tick();
        abort = 1; tick(); abort = 0;

        // 4: abort mid-burst, offered beat discarded
        start = 1; tick(); start = 0;
        beat(4, 4); beat(4, 4);
        abort = 1; in_valid = 1; tick();
        abort = 0; in_valid = 0;
        @(negedge clk);
        chk("t4_busy", int'(busy4), 0);
        chk("t4_tout", int'(tout4), 0);
        tick();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) beat(1, 2);
        wait_ld(0, 3);
        chk("t4_tout8", int'(tout4), 8);
        tick();
        start = 1; abort = 1; tick();
        start = 0; abort = 0;
        @(negedge clk);
        chk("t4_abort_wins", int'(busy4), 0);

        // 5: asynchronous reset mid-burst
        tick();
        start = 1; tick(); start = 0;
        beat(1, 1); beat(1, 1); beat(1, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_tout", int'(tout4), 0);
        chk("t5_busy", int'(busy4), 0);
        chk("t5_ready", int'(rdy4), 0);
        chk("t5_ovf20", int'(ovf20), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_no_ld", int'(ld4 | ld20), 0);
        end

        // 6: start held high, continuous beats
        do_reset();
        start = 1; in_valid = 1; a_in = 2; b_in = 3;
        wait_ld(0, 10);
        chk("t6_tout", int'(tout4), 24);
        @(negedge clk);
        chk("t6_idle_gap", int'(busy4), 0);
        @(negedge clk);
        chk("t6_restart", int'(busy4), 1);
        wait_ld(0, 10);
        chk("t6_tout2", int'(tout4), 24);
        tick();
        start = 0; in_valid = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
